// File: rtl/mmio_port_bank.sv
// -----------------------------------------------------------------------------
// mmio_port_bank
//   Memory-mapped register bank on the data-memory bus. It holds NUM_OUT
//   byte-wide output ports and one synchronised input port. Rising edges on
//   the input port set sticky flags that are cleared by writing 1 to them.
//   Read data is registered, so it is valid one clock after the address.
//
//   Byte map (offset from BASE_ADDR):
//     0x00..NUM_OUT-1  OUT[i]    read/write
//     0x10             IN        read-only, zero-extended
//     0x11             reserved  reads 0
//     0x12             EDGE      write-1-to-clear
//     0x13             MASK      read/write only with the irq option
//   Lane rule: an even register always takes wdata[7:0] and an odd register
//   always takes wdata[15:8]. A word access at an even address covers the pair.
//
//   Optional feature macro: MMIO_PORT_BANK_IRQ_EN
//     defined   -> MASK register plus registered irq = |(EDGE & MASK)
//     undefined -> MASK reads 0 and ignores writes, irq tied to 0
// -----------------------------------------------------------------------------
module mmio_port_bank #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int unsigned BASE_ADDR   = 32'h0000_0080,
    parameter int          NUM_OUT     = 4,
    parameter int          IN_WIDTH    = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  OUT_RESET   = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen,
    input  logic                    byt,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [15:0]             wdata,
    output logic [15:0]             rdata,
    input  logic [IN_WIDTH-1:0]     in_raw,
    output logic [NUM_OUT*8-1:0]    out_port,
    output logic                    irq
);

    // Offsets of the fixed registers inside the bank
    localparam logic [4:0] OFF_IN   = 5'h10;
    localparam logic [4:0] OFF_EDGE = 5'h12;
    localparam logic [4:0] OFF_MASK = 5'h13;

    // One bit wider than the address so that addresses below the base wrap
    // to a large value and fall outside the bank.
    localparam logic [ADDR_WIDTH:0] BASE_X = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] SPAN_X = (ADDR_WIDTH+1)'(20);

    // ------------------------------------------------------------------
    // Address decode and lane write strobes
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH:0] w_off_full;
    logic                w_hit;
    logic [4:0]          w_off;
    logic [4:0]          w_lo_off;
    logic [4:0]          w_hi_off;
    logic                w_wr_lo;
    logic                w_wr_hi;

    // Decode the bank offset and which byte lanes this access writes
    always_comb begin
        w_off_full = {1'b0, addr} - BASE_X;
        w_hit      = (w_off_full < SPAN_X);
        w_off      = w_off_full[4:0];
        w_lo_off   = {w_off[4:1], 1'b0};
        w_hi_off   = {w_off[4:1], 1'b1};
        // Even register: only an access at the even address itself
        w_wr_lo    = wen & w_hit & ~w_off[0];
        // Odd register: any access at the odd address, or a word at the even one
        w_wr_hi    = wen & w_hit & (w_off[0] | ~byt);
    end

    // ------------------------------------------------------------------
    // Output port registers
    // ------------------------------------------------------------------
    logic [NUM_OUT*8-1:0] r_out;

    // Output byte registers; lane parity picks the matching data byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= {NUM_OUT{OUT_RESET}};
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_wr_lo && (w_lo_off == 5'(i))) begin
                    r_out[i*8 +: 8] <= wdata[7:0];
                end else if (w_wr_hi && (w_hi_off == 5'(i))) begin
                    r_out[i*8 +: 8] <= wdata[15:8];
                end else begin
                    r_out[i*8 +: 8] <= r_out[i*8 +: 8];
                end
            end
        end
    end

    assign out_port = r_out;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [IN_WIDTH-1:0] r_in_prev;
    logic [IN_WIDTH-1:0] r_edge;
    logic [IN_WIDTH-1:0] w_in_s;
    logic [IN_WIDTH-1:0] w_rise;
    logic [IN_WIDTH-1:0] w_clr;

    // Synchroniser chain; stages reset low, so a pin that is already high
    // at reset release still produces one rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_in_prev <= '0;
        end else begin
            r_sync[0] <= in_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_in_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Rising-edge detect and write-1-to-clear mask for the flag register
    always_comb begin
        w_in_s = r_sync[SYNC_STAGES-1];
        w_rise = w_in_s & ~r_in_prev;
        if (w_wr_lo && (w_lo_off == OFF_EDGE)) begin
            w_clr = wdata[IN_WIDTH-1:0];
        end else begin
            w_clr = '0;
        end
    end

    // Sticky edge flags; a new edge wins over a clear on the same bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_rise;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt mask and request
    // ------------------------------------------------------------------
    logic [IN_WIDTH-1:0] w_mask;

`ifdef MMIO_PORT_BANK_IRQ_EN
    logic [IN_WIDTH-1:0] r_mask;
    logic                r_irq;

    // Mask register lives in the odd lane of the EDGE/MASK pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_wr_hi && (w_hi_off == OFF_MASK)) begin
            r_mask <= wdata[8 +: IN_WIDTH];
        end else begin
            r_mask <= r_mask;
        end
    end

    // Registered interrupt: follows the masked flags one clock later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign w_mask = r_mask;
    assign irq    = r_irq;
`else
    assign w_mask = '0;
    assign irq    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0]  w_in_byte;
    logic [7:0]  w_edge_byte;
    logic [7:0]  w_mask_byte;
    logic [15:0] r_rdata;

    // Zero-extend the narrow input-side registers to a byte
    always_comb begin
        w_in_byte   = 8'h00;
        w_edge_byte = 8'h00;
        w_mask_byte = 8'h00;
        w_in_byte[IN_WIDTH-1:0]   = w_in_s;
        w_edge_byte[IN_WIDTH-1:0] = r_edge;
        w_mask_byte[IN_WIDTH-1:0] = w_mask;
    end

    // Read value of one in-bank byte offset; holes read zero
    function automatic logic [7:0] rd_byte(input logic [4:0] off);
        logic [7:0] b;
        b = 8'h00;
        if (off < 5'(NUM_OUT)) begin
            b = r_out[{off[3:0], 3'b000} +: 8];
        end else begin
            case (off)
                OFF_IN:   b = w_in_byte;
                OFF_EDGE: b = w_edge_byte;
                OFF_MASK: b = w_mask_byte;
                default:  b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Registered read of the aligned pair; sees pre-write register values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 16'h0000;
        end else if (w_hit) begin
            r_rdata <= {rd_byte(w_hi_off), rd_byte(w_lo_off)};
        end else begin
            r_rdata <= 16'h0000;
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_mmio_port_bank.sv
// -----------------------------------------------------------------------------
// tb_mmio_port_bank
//   Table-driven bench for mmio_port_bank with default parameters
//   (BASE 0x080, NUM_OUT 4, IN_WIDTH 8, SYNC_STAGES 2), plus hand-written
//   sequences for edge flags, set-wins-over-clear, read-during-write and
//   reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_mmio_port_bank;

`ifdef MMIO_PORT_BANK_IRQ_EN
    localparam logic [7:0] EXP_MASK = 8'h01;
    localparam logic       EXP_IRQ  = 1'b1;
`else
    localparam logic [7:0] EXP_MASK = 8'h00;
    localparam logic       EXP_IRQ  = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wen;
    logic        byt;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [7:0]  in_raw;
    logic [31:0] out_port;
    logic        irq;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic        wen;
        logic        byt;
        logic [9:0]  waddr;
        logic [15:0] wdata;
        logic [9:0]  raddr;
        logic [15:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [12];

    mmio_port_bank dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .byt      (byt),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .in_raw   (in_raw),
        .out_port (out_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        wen    = 1'b0;
        byt    = 1'b0;
        addr   = 10'h000;
        wdata  = 16'h0000;
        in_raw = 8'h00;

        //               name        wen   byt   waddr    wdata      raddr    exp_rd     exp_out
        vecs[0]  = '{"word_wr_0",    1'b1, 1'b0, 10'h080, 16'hA55A, 10'h081, 16'hA55A, 32'h0000A55A};
        vecs[1]  = '{"byte_wr_3",    1'b1, 1'b1, 10'h083, 16'h3C00, 10'h082, 16'h3C00, 32'h3C00A55A};
        vecs[2]  = '{"byte_wr_2",    1'b1, 1'b1, 10'h082, 16'h0011, 10'h083, 16'h3C11, 32'h3C11A55A};
        vecs[3]  = '{"word_wr_odd",  1'b1, 1'b0, 10'h083, 16'h77EE, 10'h082, 16'h7711, 32'h7711A55A};
        vecs[4]  = '{"byte_wr_0",    1'b1, 1'b1, 10'h080, 16'hBEEF, 10'h080, 16'hA5EF, 32'h7711A5EF};
        vecs[5]  = '{"wen_low",      1'b0, 1'b0, 10'h080, 16'h1234, 10'h080, 16'hA5EF, 32'h7711A5EF};
        vecs[6]  = '{"unmap_hi",     1'b1, 1'b0, 10'h0A0, 16'h1234, 10'h0A0, 16'h0000, 32'h7711A5EF};
        vecs[7]  = '{"unmap_lo",     1'b1, 1'b0, 10'h07E, 16'hFFFF, 10'h07E, 16'h0000, 32'h7711A5EF};
        vecs[8]  = '{"in_rdonly",    1'b1, 1'b0, 10'h090, 16'hFFFF, 10'h090, 16'h0000, 32'h7711A5EF};
        vecs[9]  = '{"mask_wr",      1'b1, 1'b0, 10'h092, 16'h0101, 10'h092, {EXP_MASK, 8'h00}, 32'h7711A5EF};
        vecs[10] = '{"out4_hole",    1'b1, 1'b0, 10'h084, 16'h5555, 10'h084, 16'h0000, 32'h7711A5EF};
        vecs[11] = '{"byte_wr_1",    1'b1, 1'b1, 10'h081, 16'h12C3, 10'h080, 16'h12EF, 32'h771112EF};

        // Reset state
        #1;
        chk("rst_out",   out_port, 32'h00000000);
        chk("rst_rdata", {16'h0000, rdata}, 32'h00000000);
        chk("rst_irq",   {31'd0, irq}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Table: write (or not), then read back and compare
        for (int i = 0; i < 12; i++) begin
            wen   = vecs[i].wen;
            byt   = vecs[i].byt;
            addr  = vecs[i].waddr;
            wdata = vecs[i].wdata;
            cyc();
            wen   = 1'b0;
            byt   = 1'b0;
            addr  = vecs[i].raddr;
            cyc();
            chk({vecs[i].name, "_rd"},  {16'h0000, rdata}, {16'h0000, vecs[i].exp_rd});
            chk({vecs[i].name, "_out"}, out_port, vecs[i].exp_out);
        end

        // Read in the same cycle as a write returns the old value
        wen = 1'b1; byt = 1'b0; addr = 10'h080; wdata = 16'h0F0F;
        cyc();
        chk("rdw_old", {16'h0000, rdata}, 32'h000012EF);
        wen = 1'b0;
        cyc();
        chk("rdw_new", {16'h0000, rdata}, 32'h00000F0F);

        // Rising edge on bit 0: flag after 3 clocks, visible on rdata one later
        addr = 10'h092; in_raw = 8'h01;
        cyc(); cyc(); cyc();
        chk("edge_lat3_rd", {24'd0, rdata[7:0]}, 32'd0);
        chk("edge_lat3_irq", {31'd0, irq}, 32'd0);
        cyc();
        chk("edge_set_rd", {16'h0000, rdata}, {16'h0000, EXP_MASK, 8'h01});
        chk("edge_irq", {31'd0, irq}, {31'd0, EXP_IRQ});
        // Clear with write-1
        wen = 1'b1; byt = 1'b1; wdata = 16'h0001;
        cyc();
        wen = 1'b0;
        chk("clr_pre_rd", {24'd0, rdata[7:0]}, 32'h01);
        chk("clr_pre_irq", {31'd0, irq}, {31'd0, EXP_IRQ});
        cyc();
        chk("clr_rd", {24'd0, rdata[7:0]}, 32'h00);
        chk("clr_irq", {31'd0, irq}, 32'd0);

        // Set wins when a new edge lands in the clear cycle
        in_raw = 8'h00;
        cyc(); cyc(); cyc(); cyc();
        in_raw = 8'h01;
        cyc(); cyc();
        wen = 1'b1; byt = 1'b1; wdata = 16'h0001;
        cyc();
        wen = 1'b0;
        cyc();
        chk("set_wins_rd", {24'd0, rdata[7:0]}, 32'h01);

        // Reset asserted in the middle of a write
        @(negedge clk);
        wen = 1'b1; byt = 1'b0; addr = 10'h080; wdata = 16'hFFFF;
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_out",   out_port, 32'h00000000);
        chk("rstw_rdata", {16'h0000, rdata}, 32'h00000000);
        chk("rstw_irq",   {31'd0, irq}, 32'd0);
        cyc();
        rst = 1'b0; wen = 1'b0; addr = 10'h080;
        cyc();
        chk("rstw_rd0", {16'h0000, rdata}, 32'h00000000);
        chk("rstw_out2", out_port, 32'h00000000);
        // in_raw still high at release: one edge after synchronisation
        addr = 10'h092;
        cyc(); cyc();
        chk("rst_pin_early", {16'h0000, rdata}, 32'h00000000);
        cyc();
        chk("rst_pin_edge", {16'h0000, rdata}, 32'h00000001);
        chk("rst_pin_irq", {31'd0, irq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
